// File: rtl/mux_pkg.sv
// Shared constants for the 4-to-1 lane selector: select encodings and lane count.
package mux_pkg;
   localparam int unsigned NUM_LANES = 4;

   localparam logic [1:0] SEL_L0 = 2'd0;
   localparam logic [1:0] SEL_L1 = 2'd1;
   localparam logic [1:0] SEL_L2 = 2'd2;
   localparam logic [1:0] SEL_L3 = 2'd3;
endpackage : mux_pkg

// File: rtl/mux_4x1_core.sv
// Combinational 4-to-1 lane selector; lane k lives at ips[k*DATA_W +: DATA_W].
module mux_4x1_core
   import mux_pkg::*;
#(
   parameter int unsigned DATA_W = 1
) (
   input  logic [1:0]                  sel,
   input  logic [NUM_LANES*DATA_W-1:0] ips,
   output logic [DATA_W-1:0]           y
);

   logic [DATA_W-1:0] w_lane0;
   logic [DATA_W-1:0] w_lane1;
   logic [DATA_W-1:0] w_lane2;
   logic [DATA_W-1:0] w_lane3;

   assign w_lane0 = ips[0*DATA_W +: DATA_W];
   assign w_lane1 = ips[1*DATA_W +: DATA_W];
   assign w_lane2 = ips[2*DATA_W +: DATA_W];
   assign w_lane3 = ips[3*DATA_W +: DATA_W];

   // Default falls back to lane 0 so an unknown select never holds state.
   always_comb begin
      y = w_lane0;
      case (sel)
         SEL_L0:  y = w_lane0;
         SEL_L1:  y = w_lane1;
         SEL_L2:  y = w_lane2;
         SEL_L3:  y = w_lane3;
         default: y = w_lane0;
      endcase
   end

endmodule : mux_4x1_core

// File: rtl/mux_4x1.sv
// 4-to-1 selector with a combinational output and an enable-gated registered copy.
module mux_4x1
   import mux_pkg::*;
#(
   parameter int unsigned DATA_W = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [1:0]                  sel,
   input  logic [NUM_LANES*DATA_W-1:0] ips,
   input  logic                        en,
   output logic [DATA_W-1:0]           y,
   output logic [DATA_W-1:0]           y_q,
   output logic [1:0]                  sel_q
);

   logic [DATA_W-1:0] w_y;
   logic [DATA_W-1:0] r_y_q;
   logic [1:0]        r_sel_q;

   mux_4x1_core #(
      .DATA_W (DATA_W)
   ) u_core (
      .sel (sel),
      .ips (ips),
      .y   (w_y)
   );

   // Reset takes priority over capture enable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_y_q   <= '0;
         r_sel_q <= SEL_L0;
      end else if (en) begin
         r_y_q   <= w_y;
         r_sel_q <= sel;
      end
   end

   assign y     = w_y;
   assign y_q   = r_y_q;
   assign sel_q = r_sel_q;

endmodule : mux_4x1

// File: tb/tb_mux_4x1.sv
// Bench for mux_4x1: directed vector tables plus register/reset sequences, DATA_W=1 and 4.
module tb_mux_4x1;

   typedef struct {
      logic [1:0]  sel;
      logic [15:0] ips;
      logic [3:0]  y;
   } vec_t;

   logic        clk;
   logic        clk_run;
   logic        rst;
   logic        en;
   logic [1:0]  sel;
   logic [3:0]  ips1;
   logic [15:0] ips4;
   logic        y1;
   logic        y_q1;
   logic [1:0]  sel_q1;
   logic [3:0]  y4;
   logic [3:0]  y_q4;
   logic [1:0]  sel_q4;

   int n_checks;
   int n_errors;

   mux_4x1 #(.DATA_W(1)) dut1 (
      .clk   (clk),
      .rst   (rst),
      .sel   (sel),
      .ips   (ips1),
      .en    (en),
      .y     (y1),
      .y_q   (y_q1),
      .sel_q (sel_q1)
   );

   mux_4x1 #(.DATA_W(4)) dut4 (
      .clk   (clk),
      .rst   (rst),
      .sel   (sel),
      .ips   (ips4),
      .en    (en),
      .y     (y4),
      .y_q   (y_q4),
      .sel_q (sel_q4)
   );

   initial clk = 1'b0;
   always #5 if (clk_run) clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic edge_then_settle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t v1 [4];
      vec_t v4 [4];
      logic [3:0] pat;

      n_checks = 0;
      n_errors = 0;
      v1[0] = '{sel: 2'b00, ips: 16'b1100, y: 4'h0};
      v1[1] = '{sel: 2'b01, ips: 16'b1101, y: 4'h0};
      v1[2] = '{sel: 2'b10, ips: 16'b1010, y: 4'h0};
      v1[3] = '{sel: 2'b11, ips: 16'b1100, y: 4'h1};
      v4[0] = '{sel: 2'd0, ips: 16'hDCBA, y: 4'hA};
      v4[1] = '{sel: 2'd1, ips: 16'hDCBA, y: 4'hB};
      v4[2] = '{sel: 2'd2, ips: 16'hDCBA, y: 4'hC};
      v4[3] = '{sel: 2'd3, ips: 16'hDCBA, y: 4'hD};

      clk_run = 1'b0;
      rst  = 1'b1;
      en   = 1'b0;
      sel  = 2'b00;
      ips1 = 4'b0000;
      ips4 = 16'h0000;
      #10;
      chk("reset_y_q1",   16'(y_q1),   16'h0);
      chk("reset_sel_q1", 16'(sel_q1), 16'h0);
      chk("reset_y_q4",   16'(y_q4),   16'h0);
      chk("reset_sel_q4", 16'(sel_q4), 16'h0);

      // Clock stopped, reset held: y must still track.
      for (int p = 0; p < 16; p++) begin
         for (int s = 0; s < 4; s++) begin
            pat  = 4'(p);
            sel  = 2'(s);
            ips1 = pat;
            #10;
            chk("exh_rst_y", 16'(y1), 16'(pat[s]));
         end
      end

      rst = 1'b0;
      clk_run = 1'b1;

      for (int i = 0; i < 4; i++) begin
         sel  = v1[i].sel;
         ips1 = v1[i].ips[3:0];
         #10;
         chk("comb_vec_y1", 16'(y1), 16'(v1[i].y[0]));
      end

      for (int i = 0; i < 4; i++) begin
         sel  = v4[i].sel;
         ips4 = v4[i].ips;
         #10;
         chk("width4_y", 16'(y4), 16'(v4[i].y));
      end

      for (int p = 0; p < 16; p++) begin
         for (int s = 0; s < 4; s++) begin
            pat  = 4'(p);
            sel  = 2'(s);
            ips1 = pat;
            #10;
            chk("exh_y", 16'(y1), 16'(pat[s]));
         end
      end

      // Registered capture then hold with en low.
      @(negedge clk);
      sel = 2'b11; ips1 = 4'b1000; ips4 = 16'hDCBA; en = 1'b1;
      edge_then_settle();
      chk("cap_y_q1",   16'(y_q1),   16'h1);
      chk("cap_sel_q1", 16'(sel_q1), 16'h3);
      chk("cap_y_q4",   16'(y_q4),   16'hD);
      @(negedge clk);
      en = 1'b0; ips1 = 4'b0000; sel = 2'b01; ips4 = 16'h1234;
      edge_then_settle();
      chk("hold_y_q1",   16'(y_q1),   16'h1);
      chk("hold_sel_q1", 16'(sel_q1), 16'h3);
      chk("hold_y_q4",   16'(y_q4),   16'hD);

      // Asynchronous reset between edges.
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("async_y_q1",   16'(y_q1),   16'h0);
      chk("async_sel_q1", 16'(sel_q1), 16'h0);
      chk("async_y_q4",   16'(y_q4),   16'h0);
      @(negedge clk);
      rst = 1'b0; sel = 2'b10; ips1 = 4'b0100; ips4 = 16'h0500;
      edge_then_settle();
      chk("post_rst_noen_y_q1", 16'(y_q1), 16'h0);
      @(negedge clk);
      en = 1'b1;
      edge_then_settle();
      chk("resume_y_q1",   16'(y_q1),   16'h1);
      chk("resume_sel_q1", 16'(sel_q1), 16'h2);
      chk("resume_y_q4",   16'(y_q4),   16'h5);
      @(negedge clk);
      sel = 2'b01; ips1 = 4'b1101; ips4 = 16'h00E0;
      edge_then_settle();
      chk("follow_y_q1",   16'(y_q1),   16'h0);
      chk("follow_sel_q1", 16'(sel_q1), 16'h1);
      chk("follow_y_q4",   16'(y_q4),   16'hE);

      // Reset wins over enable.
      @(negedge clk);
      rst = 1'b1; en = 1'b1; ips1 = 4'b1111; ips4 = 16'hFFFF; sel = 2'b11;
      for (int k = 0; k < 3; k++) begin
         edge_then_settle();
         chk("prio_y_q1",   16'(y_q1),   16'h0);
         chk("prio_sel_q1", 16'(sel_q1), 16'h0);
         chk("prio_y_q4",   16'(y_q4),   16'h0);
      end
      chk("prio_y_comb", 16'(y1), 16'h1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_mux_4x1
